opt_sequencer: RTL and testbench
================================

# opt_sequencer

Parametrised option sequencer that feeds the clock/timer FSM with `{option, valid}` commands from either the user inputs (manual mode) or a writable program memory played back on a divided tick (single-pass or looping). It replaces the fixed 16-entry ROM-plus-counter source with:
- a run-time programmable sequence of configurable length;
- a ready/valid handshake toward the FSM;
- tick-overrun detection.

## Interface
- `OPT_W`, 3, option width
- `ADDR_W`, 4, program address width; depth = 2**ADDR_W
- `DIV_MAX`, 500000, clk cycles per playback tick (≥2)
- `DIV_W`, 19, divider counter width; must hold DIV_MAX-1

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  00 manual, 01 auto single-pass, 10 auto loop, 11 reserved (treated as manual)
- `start`  in  1  pulse; begins operation in the latched mode
- `stop`  in  1  pulse; abort to IDLE
- `user_opt`  in  OPT_W  manual option
- `user_valid`  in  1  manual strobe
- `prog_wr_en`  in  1  program write enable
- `prog_addr`  in  ADDR_W  program write address
- `prog_data`  in  OPT_W  program write data
- `seq_len`  in  ADDR_W+1  entries to play (0..2**ADDR_W)
- `opt_ready`  in  1  FSM accepts option
- `opt_out`  out  OPT_W  option to FSM
- `opt_valid`  out  1  option valid
- `seq_addr`  out  ADDR_W  current playback address
- `busy`  out  1  not in IDLE/DONE
- `done`  out  1  single-pass completed
- `overrun`  out  1  sticky: tick arrived while ISSUE pending

## Operation
States:
- IDLE
  - `start` latches `mode` and `seq_len`.
  - Manual → MANUAL.
  - Auto with `seq_len`=0 → DONE.
  - Auto otherwise → WAIT_TICK with addr=0.
- MANUAL: `user_valid` high → capture `user_opt` → ISSUE.
- WAIT_TICK: `tick` → FETCH.
- FETCH: one cycle; synchronous program read of addr → ISSUE.
- ISSUE: `opt_valid`=1 with `opt_out` stable until the cycle `opt_ready`=1. On acceptance:
  - manual → MANUAL;
  - auto with addr < len-1 → addr+1, WAIT_TICK;
  - last entry, single-pass → DONE;
  - last entry, loop → addr=0, WAIT_TICK.
- DONE: `done`=1; `start` restarts (same rules as IDLE).

Program memory and playback:
- Program memory writes are accepted in any state and take effect on the next read.
- Writing the address being fetched in the same cycle returns the old data.

Priority and exceptions:
- `stop` (any state) → IDLE next cycle; drops any pending `opt_valid`. `stop` beats `start` and `opt_ready`.
- `mode` and `seq_len` changes outside IDLE/DONE are ignored until the next `start`.
- Tick while in FETCH or ISSUE is not queued: set `overrun`. `overrun` is cleared only by `start` or `rst`.
- `user_valid` outside MANUAL is ignored; in ISSUE (manual) it is dropped.

## Timing
- Reset values:
  - state IDLE;
  - `opt_out`=0, `opt_valid`=0, `seq_addr`=0;
  - `busy`=0, `done`=0, `overrun`=0;
  - divider=0.
- Program memory contents are not reset.
- `tick` is a one-cycle pulse when the divider reaches DIV_MAX-1; the divider then wraps to 0.
  - The divider is cleared by `rst` and by `start`, so the first tick comes DIV_MAX cycles after `start`.
- Auto latency: tick at cycle t → FETCH t+1 → `opt_valid` at t+2.
- Manual latency: `user_valid` at t → `opt_valid` at t+1.
- `opt_valid` falls the cycle after acceptance; back-to-back issues are impossible (minimum one WAIT cycle).
- All outputs are registered.

## Structure
- Package `opt_seq_pkg`:
  - mode encodings: MODE_MANUAL, MODE_ONCE, MODE_LOOP;
  - state enum: IDLE, MANUAL, WAIT_TICK, FETCH, ISSUE, DONE.
- Sub-module `tick_gen` (DIV_MAX, DIV_W): divider with synchronous clear, emits `tick`.
- Program memory is inferred inline: 2**ADDR_W × OPT_W, one write port, one synchronous read port.

## Test plan
All directed scenarios use DIV_MAX=4, ADDR_W=4.
- Manual: `start` with mode=00; `user_opt`=5 with `user_valid` for 1 cycle, `opt_ready`=1 → `opt_valid`=1 with `opt_out`=5 exactly one cycle later, then back to MANUAL.
- Single-pass: program [3,1,6] with `seq_len`=3, mode=01, `opt_ready` tied high → options 3,1,6 at 4-cycle spacing; `done`=1 and `busy`=0 after the third.
- Loop with backpressure: `seq_len`=2, mode=10, `opt_ready` low for 10 cycles on the first issue → `opt_out` held; `overrun`=1; `seq_addr` 0→1→0 wraps.
- Edge cases: `seq_len`=0 → DONE one cycle after `start`, no `opt_valid`. `seq_len`=16 plays addresses 0..15.
- Abort: `stop` during ISSUE, and `stop` together with `opt_ready` → IDLE next cycle, `opt_valid`=0, `seq_addr` unchanged until the next `start` resets it to 0.
- Reset mid-run: `rst` in WAIT_TICK → all outputs return to reset values; program contents preserved and replay correctly after `start`.

Source files
------------

// File: rtl/opt_seq_pkg.sv
// Shared types for the option sequencer: playback modes and controller states.
package opt_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_ONCE   = 2'b01,
        MODE_LOOP   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        MANUAL,
        WAIT_TICK,
        FETCH,
        ISSUE,
        DONE
    } state_e;

    // Reserved encoding behaves as manual, so it is folded away at latch time.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_ONCE;
            2'b10:   return MODE_LOOP;
            default: return MODE_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/opt_sequencer_tick_gen.sv
// Playback tick divider: one-cycle tick every DIV_MAX clocks, synchronous clear.
module tick_gen
    import opt_seq_pkg::*;
#(
    parameter int unsigned DIV_MAX = 500000,
    parameter int unsigned DIV_W   = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_MAX - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Count up, wrap at DIV_MAX-1, restart from zero on clear.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/opt_sequencer.sv
// Option sequencer: feeds {option, valid} to the clock/timer FSM from the user
// inputs or from a writable program played back on a divided tick.
module opt_sequencer
    import opt_seq_pkg::*;
#(
    parameter int unsigned OPT_W   = 3,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DIV_MAX = 500000,
    parameter int unsigned DIV_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic [OPT_W-1:0]  user_opt,
    input  logic              user_valid,
    input  logic              prog_wr_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [OPT_W-1:0]  prog_data,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              opt_ready,
    output logic [OPT_W-1:0]  opt_out,
    output logic              opt_valid,
    output logic [ADDR_W-1:0] seq_addr,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [OPT_W-1:0] mem [DEPTH];

    state_e            state_q,     state_d;
    mode_e             mode_q,      mode_d;
    logic [ADDR_W:0]   len_q,       len_d;
    logic [ADDR_W-1:0] seq_addr_q,  seq_addr_d;
    logic [OPT_W-1:0]  opt_out_q,   opt_out_d;
    logic              opt_valid_q, opt_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              overrun_q,   overrun_d;

    logic              tick;
    logic              start_go;
    logic [ADDR_W:0]   next_addr_ext;

    // A start only takes effect from IDLE/DONE, and stop always wins.
    assign start_go      = start && !stop && (state_q == IDLE || state_q == DONE);
    assign next_addr_ext = {1'b0, seq_addr_q} + (ADDR_W + 1)'(1);

    tick_gen #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_go),
        .tick (tick)
    );

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_wr_en) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state and next-output logic for the sequencer controller.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        seq_addr_d  = seq_addr_q;
        opt_out_d   = opt_out_q;
        opt_valid_d = opt_valid_q;
        overrun_d   = overrun_q;

        if (stop) begin
            state_d     = IDLE;
            opt_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_d     = decode_mode(mode);
                        len_d      = seq_len;
                        seq_addr_d = '0;
                        overrun_d  = 1'b0;
                        if (decode_mode(mode) == MODE_MANUAL) begin
                            state_d = MANUAL;
                        end else if (seq_len == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = WAIT_TICK;
                        end
                    end
                end
                MANUAL: begin
                    if (user_valid) begin
                        opt_out_d   = user_opt;
                        opt_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
                WAIT_TICK: begin
                    if (tick) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    // opt_out doubles as the memory read register; a write to
                    // this address in the same cycle lands after the read.
                    opt_out_d   = mem[seq_addr_q];
                    opt_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
                ISSUE: begin
                    if (opt_ready) begin
                        opt_valid_d = 1'b0;
                        if (mode_q == MODE_MANUAL) begin
                            state_d = MANUAL;
                        end else if (next_addr_ext < len_q) begin
                            seq_addr_d = next_addr_ext[ADDR_W-1:0];
                            state_d    = WAIT_TICK;
                        end else if (mode_q == MODE_LOOP) begin
                            seq_addr_d = '0;
                            state_d    = WAIT_TICK;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    opt_valid_d = 1'b0;
                end
            endcase
        end

        // Ticks only matter during playback; one landing mid-issue is lost.
        if (tick && mode_q != MODE_MANUAL && (state_q == FETCH || state_q == ISSUE)) begin
            overrun_d = 1'b1;
        end

        busy_d = !(state_d == IDLE || state_d == DONE);
        done_d = (state_d == DONE);
    end

    // Controller and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_MANUAL;
            len_q       <= '0;
            seq_addr_q  <= '0;
            opt_out_q   <= '0;
            opt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            seq_addr_q  <= seq_addr_d;
            opt_out_q   <= opt_out_d;
            opt_valid_q <= opt_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign opt_out   = opt_out_q;
    assign opt_valid = opt_valid_q;
    assign seq_addr  = seq_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_opt_sequencer.sv
// Self-checking bench for opt_sequencer with DIV_MAX=4, ADDR_W=4.
module tb_opt_sequencer;

    localparam int unsigned OPT_W   = 3;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DIV_MAX = 4;
    localparam int unsigned DIV_W   = 3;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic [1:0]        mode       = '0;
    logic              start      = 1'b0;
    logic              stop       = 1'b0;
    logic [OPT_W-1:0]  user_opt   = '0;
    logic              user_valid = 1'b0;
    logic              prog_wr_en = 1'b0;
    logic [ADDR_W-1:0] prog_addr  = '0;
    logic [OPT_W-1:0]  prog_data  = '0;
    logic [ADDR_W:0]   seq_len    = '0;
    logic              opt_ready  = 1'b0;
    logic [OPT_W-1:0]  opt_out;
    logic              opt_valid;
    logic [ADDR_W-1:0] seq_addr;
    logic              busy;
    logic              done;
    logic              overrun;

    always #5 clk = ~clk;

    opt_sequencer #(
        .OPT_W   (OPT_W),
        .ADDR_W  (ADDR_W),
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .user_opt   (user_opt),
        .user_valid (user_valid),
        .prog_wr_en (prog_wr_en),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .seq_len    (seq_len),
        .opt_ready  (opt_ready),
        .opt_out    (opt_out),
        .opt_valid  (opt_valid),
        .seq_addr   (seq_addr),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int prog_model [16];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_prog(input int a, input int d);
        prog_wr_en    = 1'b1;
        prog_addr     = ADDR_W'(a);
        prog_data     = OPT_W'(d);
        prog_model[a] = d;
        step();
        prog_wr_en    = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] m, input int len, input logic rdy);
        mode      = m;
        seq_len   = 5'(len);
        opt_ready = rdy;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Playback with opt_ready high: entry k is issued 6+4k cycles after start.
    task automatic run_auto(input int len, input bit loop, input int ncyc);
        int k;
        int adv;
        int exp_a;
        bit exp_v;
        bit exp_done;
        do_start(loop ? 2'b10 : 2'b01, len, 1'b1);
        for (int d = 1; d <= ncyc; d++) begin
            k        = (d >= 6 && (d - 6) % 4 == 0) ? (d - 6) / 4 : -1;
            exp_v    = (k >= 0) && (loop || k < len);
            adv      = (d < 7) ? 0 : (d - 7) / 4 + 1;
            exp_a    = loop ? adv % len : ((adv > len - 1) ? len - 1 : adv);
            exp_done = !loop && (d >= 4 * len + 3);
            check("auto_valid", opt_valid, exp_v);
            if (exp_v) check("auto_out", opt_out, prog_model[k % len]);
            check("auto_addr", seq_addr, exp_a);
            check("auto_done", done, exp_done);
            check("auto_busy", busy, !exp_done);
            check("auto_overrun", overrun, 0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int v2;
        int s;
        int a;
        int tk;

        // Reset state
        repeat (3) step();
        check("rst_out", opt_out, 0);
        check("rst_valid", opt_valid, 0);
        check("rst_addr", seq_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        step();

        // Manual mode, one-cycle latency, mode changes ignored while running
        do_start(2'b00, 0, 1'b1);
        check("man_busy", busy, 1);
        check("man_done", done, 0);
        check("man_idle_valid", opt_valid, 0);
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 7));
            if (i == 1) mode = 2'b01;
            user_opt   = OPT_W'(v);
            user_valid = 1'b1;
            step();
            user_valid = 1'b0;
            check("man_valid", opt_valid, 1);
            check("man_out", opt_out, v);
            step();
            check("man_accept", opt_valid, 0);
            step();
            check("man_back", opt_valid, 0);
            check("man_busy2", busy, 1);
        end

        // user_valid during a pending manual issue is dropped
        v  = int'($urandom_range(0, 7));
        v2 = (v + 1) % 8;
        opt_ready  = 1'b0;
        user_opt   = OPT_W'(v);
        user_valid = 1'b1;
        step();
        check("drop_valid", opt_valid, 1);
        user_opt = OPT_W'(v2);
        step();
        user_valid = 1'b0;
        check("drop_hold_out", opt_out, v);
        check("drop_hold_valid", opt_valid, 1);
        opt_ready = 1'b1;
        step();
        check("drop_accept", opt_valid, 0);
        step();
        check("drop_noissue", opt_valid, 0);
        pulse_stop();

        // Reserved mode behaves as manual
        do_start(2'b11, 0, 1'b1);
        v = int'($urandom_range(0, 7));
        user_opt   = OPT_W'(v);
        user_valid = 1'b1;
        step();
        user_valid = 1'b0;
        check("rsvd_valid", opt_valid, 1);
        check("rsvd_out", opt_out, v);
        pulse_stop();

        // Single-pass [3,1,6]
        write_prog(0, 3);
        write_prog(1, 1);
        write_prog(2, 6);
        run_auto(3, 1'b0, 18);

        // Loop with backpressure on the first issue
        write_prog(0, int'($urandom_range(0, 7)));
        write_prog(1, int'($urandom_range(0, 7)));
        do_start(2'b10, 2, 1'b0);
        s = cyc - 1;
        repeat (5) step();
        check("bp_valid", opt_valid, 1);
        check("bp_out0", opt_out, prog_model[0]);
        check("bp_ovr_pre", overrun, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_valid", opt_valid, 1);
            check("bp_hold_out", opt_out, prog_model[0]);
        end
        check("bp_overrun", overrun, 1);
        check("bp_addr0", seq_addr, 0);
        opt_ready = 1'b1;
        a = cyc;
        step();
        check("bp_drop", opt_valid, 0);
        check("bp_addr1", seq_addr, 1);
        for (int e = 1; e >= 0; e--) begin
            tk = s + 4;
            while (tk <= a) tk += 4;
            for (int n = 0; n < 12 && !opt_valid; n++) step();
            check("bp_wait_valid", opt_valid, 1);
            check("bp_issue_cycle", cyc, tk + 2);
            check("bp_out", opt_out, prog_model[e]);
            check("bp_addr", seq_addr, e);
            a = cyc;
            step();
            check("bp_next_addr", seq_addr, (e + 1) % 2);
            check("bp_fall", opt_valid, 0);
        end
        pulse_stop();
        check("bp_sticky", overrun, 1);
        check("bp_stop_busy", busy, 0);

        // seq_len = 0 finishes immediately; start clears overrun
        do_start(2'b01, 0, 1'b1);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_overrun", overrun, 0);
        for (int i = 0; i < 6; i++) begin
            check("len0_valid", opt_valid, 0);
            step();
        end

        // Full-depth single pass with random program
        for (int i = 0; i < 16; i++) write_prog(i, int'($urandom_range(0, 7)));
        run_auto(16, 1'b0, 16 * 4 + 6);

        // Loop over five entries
        run_auto(5, 1'b1, 40);
        pulse_stop();

        // Abort during ISSUE, and stop together with opt_ready
        write_prog(0, 5);
        write_prog(1, 2);
        write_prog(2, 7);
        do_start(2'b01, 3, 1'b0);
        repeat (5) step();
        check("ab1_valid", opt_valid, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("ab1_valid_drop", opt_valid, 0);
        check("ab1_busy", busy, 0);
        check("ab1_done", done, 0);
        check("ab1_addr", seq_addr, 0);
        repeat (3) begin
            step();
            check("ab1_quiet", opt_valid, 0);
        end
        do_start(2'b01, 3, 1'b1);
        repeat (9) step();
        check("ab2_valid", opt_valid, 1);
        check("ab2_addr", seq_addr, 1);
        check("ab2_out", opt_out, prog_model[1]);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("ab2_valid_drop", opt_valid, 0);
        check("ab2_addr_kept", seq_addr, 1);
        check("ab2_busy", busy, 0);
        repeat (3) begin
            step();
            check("ab2_addr_hold", seq_addr, 1);
            check("ab2_quiet", opt_valid, 0);
        end
        do_start(2'b00, 0, 1'b1);
        check("ab_restart_addr", seq_addr, 0);
        check("ab_restart_busy", busy, 1);
        pulse_stop();

        // Reset during WAIT_TICK; program must survive
        do_start(2'b01, 3, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_out", opt_out, 0);
        check("mrst_valid", opt_valid, 0);
        check("mrst_addr", seq_addr, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_overrun", overrun, 0);
        run_auto(3, 1'b0, 18);

        // Write to the fetched address in the FETCH cycle returns old data
        write_prog(0, 4);
        do_start(2'b01, 1, 1'b1);
        repeat (4) step();
        prog_wr_en = 1'b1;
        prog_addr  = '0;
        prog_data  = 3'd1;
        step();
        prog_wr_en = 1'b0;
        check("wf_valid", opt_valid, 1);
        check("wf_old_data", opt_out, 4);
        prog_model[0] = 1;
        step();
        check("wf_done", done, 1);
        run_auto(1, 1'b0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
